// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS-subset datapath: sequences fetch,
// decode, execute, memory and writeback, and stalls on the memory handshake.
module multicycle_controller #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_memready;
  logic       w_funct_ok;
  logic       w_illegal;
  logic [1:0] w_aluop;
  logic       w_irwrite;
  logic       w_pcen;
  logic       w_memwrite;
  logic       w_regwrite;

  // memready is a level qualifier sampled at the clock edge: FETCH, MEMRD and
  // MEMWR hold their outputs and stay put until it is 1 in the same cycle.
  assign w_memready = MEM_WAIT_EN ? memready : 1'b1;

  always_comb begin
    w_funct_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: w_funct_ok = 1'b1;
      default: w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_illegal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_illegal = 1'b0;
      OP_RTYPE: w_illegal = ~w_funct_ok;
      default:  w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = w_memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = w_funct_ok ? S_EXECUTE : S_FETCH;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = w_memready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = w_memready ? S_FETCH : S_MEMWR;
      S_EXECUTE: w_next = S_ALUWB;
      S_ALUWB:   w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    w_aluop    = 2'b00;
    w_irwrite  = 1'b0;
    w_pcen     = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = w_memready;
        w_pcen    = w_memready;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = 2'b10;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        w_aluop = 2'b01;
        pcsrc   = 2'b01;
        w_pcen  = zero;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB:  w_regwrite = 1'b1;
      S_JUMP: begin
        pcsrc  = 2'b10;
        w_pcen = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset so nothing is written while reset is held.
  assign irwrite  = w_irwrite & reset;
  assign pcen     = w_pcen & reset;
  assign memwrite = w_memwrite & reset;
  assign regwrite = w_regwrite & reset;
  assign illegal  = (r_state == S_DECODE) & w_illegal & reset;
  assign state    = r_state;

  always_comb begin
    alucontrol = 3'b010;
    case (w_aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a driver plays instructions cycle by cycle
// from an instruction-level reference model; a monitor compares every cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       memready = 1'b1;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  logic [19:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
    .alucontrol(alucontrol), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  wire [19:0] act = {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                     alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal};

  function automatic bit legal(input logic [5:0] o, input logic [5:0] f);
    if (o inside {6'd35, 6'd43, 6'd4, 6'd8, 6'd2}) return 1'b1;
    return (o == 6'd0) && (f inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42});
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'd34:   return 3'b110;
      6'd36:   return 3'b000;
      6'd37:   return 3'b001;
      6'd42:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Expected outputs for one cycle spent in state st.
  function automatic logic [19:0] exp_vec(input int st, input bit mr, input bit z,
                                          input logic [5:0] o, input logic [5:0] f,
                                          input bit rst_low);
    logic e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_asa, e_pcen, e_ill;
    logic [1:0] e_asb, e_pcs;
    logic [2:0] e_alu;
    logic [3:0] e_st;
    {e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_asa, e_pcen, e_ill} = '0;
    e_asb = 2'd0;
    e_pcs = 2'd0;
    e_alu = 3'b010;
    e_st = 4'(st);
    case (st)
      0:  begin e_asb = 2'd1; e_irw = mr; e_pcen = mr; end
      1:  begin e_asb = 2'd3; e_ill = !legal(o, f); end
      2:  begin e_asa = 1'b1; e_asb = 2'd2; end
      3:  e_iord = 1'b1;
      4:  begin e_m2r = 1'b1; e_rw = 1'b1; end
      5:  begin e_iord = 1'b1; e_mw = 1'b1; end
      6:  begin e_asa = 1'b1; e_alu = rtype_alu(f); end
      7:  begin e_rd = 1'b1; e_rw = 1'b1; end
      8:  begin e_asa = 1'b1; e_alu = 3'b110; e_pcs = 2'd1; e_pcen = z; end
      9:  begin e_asa = 1'b1; e_asb = 2'd2; end
      10: e_rw = 1'b1;
      11: begin e_pcs = 2'd2; e_pcen = 1'b1; end
      default: ;
    endcase
    if (rst_low) {e_irw, e_pcen, e_mw, e_rw, e_ill} = '0;
    return {e_st, e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_asa, e_asb, e_pcs,
            e_pcen, e_alu, e_ill};
  endfunction

  task automatic cycle(input int st, input bit mr, input bit z, input logic [5:0] o,
                       input logic [5:0] f, input bit rst_low);
    @(posedge clk);
    #1;
    reset = !rst_low;
    memready = mr;
    zero = z;
    op = o;
    funct = f;
    exp_q.push_back(exp_vec(st, mr, z, o, f, rst_low));
  endtask

  task automatic do_reset(input int n, input bit rand_mr);
    for (int i = 0; i < n; i++)
      cycle(0, rand_mr ? 1'($urandom_range(0, 1)) : 1'b1, 1'($urandom_range(0, 1)),
            op, funct, 1'b1);
  endtask

  // Instruction-level model: state path from opcode, stretched by wait cycles.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit z,
                           input int wf, input int wm, input int abort_at);
    int path[$];
    int cs[$];
    bit cm[$];
    int waits;
    path = {0, 1};
    if (legal(o, f)) begin
      case (o)
        6'd35: path = {path, 2, 3, 4};
        6'd43: path = {path, 2, 5};
        6'd0:  path = {path, 6, 7};
        6'd4:  path = {path, 8};
        6'd8:  path = {path, 9, 10};
        default: path = {path, 11};
      endcase
    end
    foreach (path[i]) begin
      if (path[i] == 0 || path[i] == 3 || path[i] == 5) begin
        waits = (path[i] == 0) ? wf : wm;
        for (int k = 0; k < waits; k++) begin cs.push_back(path[i]); cm.push_back(1'b0); end
        cs.push_back(path[i]);
        cm.push_back(1'b1);
      end else begin
        cs.push_back(path[i]);
        cm.push_back(1'($urandom_range(0, 1)));
      end
    end
    for (int i = 0; i < cs.size(); i++) begin
      if (abort_at >= 0 && i >= abort_at) break;
      cycle(cs[i], cm[i], (cs[i] == 8) ? z : 1'($urandom_range(0, 1)), o, f, 1'b0);
    end
    if (abort_at >= 0 && abort_at < cs.size()) do_reset(2, 1'b1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [19:0] e;
      e = exp_q.pop_front();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t state=%0d got=%h exp=%h", $time, state, act, e);
      end
    end
  end

  initial begin
    logic [5:0] ops[7];
    logic [5:0] fns[6];
    logic [5:0] o, f;
    int ab;
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2, 6'd0};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
    op = 6'd0;
    funct = 6'b100000;
    do_reset(3, 1'b0);
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, -1);
    run_instr(6'b100011, 6'd0, 1'b0, 2, 3, -1);
    run_instr(6'b101011, 6'd0, 1'b0, 0, 0, -1);
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0, -1);
    run_instr(6'b000100, 6'd0, 1'b0, 0, 0, -1);
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0, -1);
    run_instr(6'b000000, 6'b000111, 1'b0, 0, 0, -1);
    run_instr(6'b000010, 6'd0, 1'b0, 0, 0, -1);
    run_instr(6'b001000, 6'd0, 1'b0, 0, 0, -1);
    run_instr(6'b101011, 6'd0, 1'b0, 1, 2, -1);
    run_instr(6'b100011, 6'd0, 1'b0, 0, 0, 3);
    run_instr(6'b101011, 6'd0, 1'b0, 0, 2, 4);
    for (int n = 0; n < 300; n++) begin
      o = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) o = 6'($urandom_range(0, 63));
      f = fns[$urandom_range(0, 5)];
      if (f == 6'd0) f = 6'($urandom_range(0, 63));
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : -1;
      run_instr(o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 3), ab);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences a multicycle MIPS-subset datapath.
- The datapath has one shared instruction/data memory port, one ALU reused for PC increment, address calculation and execute, and internal IR/A/B/ALUOut registers.
- The controller decodes opcode/funct, steps the datapath through fetch/decode/execute/memory/writeback, and stalls on a memory ready handshake.
- It replaces the single-cycle controller when the core moves to a multicycle datapath.

Parameters:
- MEM_WAIT_EN, 1, when 1 the FETCH/MEMRD/MEMWR states wait for memready; when 0, memready is ignored and treated as 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- op  input  6  instr[31:26] from the IR.
- funct  input  6  instr[5:0] from the IR.
- zero  input  1  ALU zero flag.
- memready  input  1  memory has completed the current read/write this cycle.
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- memwrite  output  1  memory write strobe.
- irwrite  output  1  load the IR from memory read data.
- regdst  output  1  destination register: 0=rt, 1=rd.
- memtoreg  output  1  writeback data: 0=ALUOut, 1=memory data register.
- regwrite  output  1  register file write enable.
- alusrca  output  1  ALU A input: 0=PC, 1=A register.
- alusrcb  output  2  ALU B input: 00=B, 01=constant 4, 10=signimm, 11=signimm<<2.
- pcsrc  output  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target.
- pcen  output  1  PC register enable.
- alucontrol  output  3  ALU operation.
- illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode or funct.
- state  output  4  current state encoding, for debug.

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
  - Unused encodings go to FETCH on the next clock.
- Reset:
  - While reset=0, state is forced to FETCH.
  - irwrite, pcen, memwrite, regwrite and illegal are forced to 0.
  - After release, the first rising edge starts a normal FETCH.
  - Reset asserted mid-instruction aborts it: no register or memory write occurs in later cycles.
- Outputs are a function of state only, except pcen (uses zero) and the memready-qualified strobes. All outputs not listed for a state are 0.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, pcsrc=00, aluop=00.
  - irwrite=memready and pcen=memready.
  - If memready=0, stay in FETCH. If memready=1, go to DECODE.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00 (computes branch target into ALUOut).
  - Next state by op: lw 100011 or sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BRANCH; addi 001000 -> ADDIEX; j 000010 -> JUMP.
  - Any other op -> FETCH with illegal=1.
  - R-type with an unsupported funct -> FETCH with illegal=1; no regwrite occurs.
- MEMADR:
  - alusrca=1, alusrcb=10, aluop=00.
  - lw -> MEMRD; sw -> MEMWR.
- MEMRD:
  - iord=1.
  - Wait until memready=1, then go to MEMWB.
- MEMWB:
  - regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR:
  - iord=1 and memwrite=1, held for every cycle in the state.
  - On memready=1, go to FETCH; the write is counted exactly once.
- EXECUTE:
  - alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB:
  - regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, aluop=01, pcsrc=01.
  - pcen=zero -> FETCH.
- ADDIEX:
  - alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB:
  - regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JUMP:
  - pcsrc=10, pcen=1 -> FETCH.
- ALU decode:
  - aluop=00 -> 010 (add); aluop=01 -> 110 (sub).
  - aluop=10 decodes funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct -> 010.
- Latency with no memory wait:
  - lw 5 cycles; sw and R-type 4; addi 4; beq 3; j 3.
  - Each memready=0 cycle in FETCH, MEMRD or MEMWR adds 1 cycle.
- With MEM_WAIT_EN=0, memready is treated as 1 in every state.

Test Plan:
- Reset held low for 3 cycles, then released, with memready=1 and op=000000, funct=100000 -> state=0 during reset with pcen=irwrite=regwrite=memwrite=0; after release the sequence is 0,1,6,7,0, with regwrite=1 and regdst=1 only in state 7, and alucontrol=010 in state 6.
- lw (op=100011) with memready=0 for 2 cycles in FETCH and 3 cycles in MEMRD -> FETCH lasts 3 cycles with irwrite=1 only in its last cycle; the full sequence is 0,0,0,1,2,3,3,3,3,4,0; memtoreg=1 and regwrite=1 in state 4.
- sw (op=101011) with memready=1 -> sequence 0,1,2,5,0; memwrite=1 and iord=1 for exactly one cycle; regwrite stays 0 throughout.
- beq (op=000100) run twice, with zero=1 and then zero=0 -> in state 8, alucontrol=110 and pcsrc=01; pcen=1 for zero=1 and pcen=0 for zero=0.
- Two decode cases:
  - op=111111 -> sequence 0,1,0 with illegal=1 in state 1 only.
  - R-type funct=000111 -> also returns to FETCH with illegal=1 and no regwrite.
- j (op=000010), then addi (op=001000) -> j gives sequence 0,1,11,0 with pcsrc=10 and pcen=1 in state 11; addi gives 0,1,9,10,0 with alusrcb=10 in state 9 and regwrite=1, regdst=0 in state 10.
